mealy_seq_det_10010_sar: RTL and testbench
==========================================

MEALY_SEQ_DET_10010_SAR -- requirements
Module: mealy_seq_det_10010_sar

Interface
REQ-001 Parameter OVERLAP, default 1, selects overlapping detection (1) or non-overlapping detection (0).
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-high (port name kept per codebase; 1 = reset asserted).
REQ-004 in  input  1  serial bit stream, one bit sampled per rising clk edge.
REQ-005 out  output  1  detect flag, high while the current in bit completes the pattern 1-0-0-1-0.

Function
REQ-006 The block SHALL be a Mealy FSM detecting the serial pattern 1,0,0,1,0 (first bit received first).
REQ-007 States SHALL be: S_IDLE (no prefix), S_1 ("1"), S_10 ("10"), S_100 ("100"), S_1001 ("1001").
REQ-008 From S_IDLE: in=1 -> S_1; in=0 -> S_IDLE.
REQ-009 From S_1: in=1 -> S_1; in=0 -> S_10.
REQ-010 From S_10: in=1 -> S_1; in=0 -> S_100.
REQ-011 From S_100: in=1 -> S_1001; in=0 -> S_IDLE.
REQ-012 From S_1001: in=1 -> S_1; in=0 -> S_10 when OVERLAP=1, or S_IDLE when OVERLAP=0.
REQ-013 out SHALL be combinational: out = 1 exactly when state==S_1001 and in==0, else 0.
REQ-014 out SHALL assert in the same cycle the fifth pattern bit is present on in (zero-cycle latency, before the capturing edge); it is high for at most one cycle per detection.
REQ-015 With OVERLAP=1, the trailing "10" of a detection SHALL count as the prefix of the next pattern (e.g. 10010010 yields two detections).
REQ-016 Unreachable/illegal state encodings SHALL transition to S_IDLE on the next edge with out=0.

Reset
REQ-017 While rst_n=1, state SHALL be S_IDLE immediately (asynchronously) and out SHALL be 0 regardless of in.
REQ-018 On release of rst_n, detection SHALL start from S_IDLE with the first sampled bit; bits before release SHALL be ignored.
REQ-019 Reset asserted mid-pattern SHALL discard the partial prefix; no detection may span a reset.

Structure
REQ-020 A shared package SHALL hold the state typedef (3-bit encoding, S_IDLE=0 ... S_1001=4) and the pattern length constant (5).
REQ-021 The design SHALL be a single module with a registered state process and a combinational next-state/output process; no sub-module is needed.

Verification
REQ-022 After reset, drive in=1,0,0,1,0 -> out=1 only during the fifth bit, 0 on all others.
REQ-023 OVERLAP=1, drive 1,0,0,1,0,0,1,0 -> out=1 during bits 5 and 8; OVERLAP=0 -> out=1 during bit 5 only.
REQ-024 Drive 1,0,1,0,1,0,0,1,0,0,1,0,1,1,0 -> exactly two pulses (bits 9 and 12 with OVERLAP=1); the trailing 1,0,1,1,0 produces none.
REQ-025 Drive 1,0,0,1, assert rst_n for one cycle, then drive 0 -> out stays 0; then 1,0,0,1,0 -> one pulse on the last bit.
REQ-026 Drive 20 cycles of all 0s, then 20 cycles of all 1s -> out stays 0 throughout.
REQ-027 Hold rst_n=1 while driving 1,0,0,1,0 -> out stays 0 and state stays S_IDLE.

Source files
------------

// File: rtl/mealy_seq_det_10010_sar_pkg.sv
// Shared definitions for the 1-0-0-1-0 serial pattern detector.
// State encoding and pattern constants live here so tools and benches agree on them.
package mealy_seq_det_10010_sar_pkg;

    localparam int unsigned PATTERN_LEN = 5;
    localparam logic [PATTERN_LEN-1:0] PATTERN = 5'b10010;

    // State name reflects the longest pattern prefix seen so far.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_100  = 3'd3,
        S_1001 = 3'd4
    } state_t;

endpackage

// File: rtl/mealy_seq_det_10010_sar.sv
// Mealy detector for the serial pattern 1,0,0,1,0 (first bit first).
// The detect flag is combinational and asserts while the fifth bit is on the input.
//
//   state  | meaning
//   -------+--------------------------------------------
//   S_IDLE | no useful prefix seen
//   S_1    | last bits are "1"
//   S_10   | last bits are "10"
//   S_100  | last bits are "100"
//   S_1001 | last bits are "1001"; a 0 now completes it
module mealy_seq_det_10010_sar
    import mealy_seq_det_10010_sar_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    state_t state;
    state_t state_nxt;
    logic   detect;

    // rst_n is an active-high reset despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        detect    = 1'b0;
        case (state)
            S_IDLE: state_nxt = in ? S_1 : S_IDLE;
            S_1:    state_nxt = in ? S_1 : S_10;
            S_10:   state_nxt = in ? S_1 : S_100;
            S_100:  state_nxt = in ? S_1001 : S_IDLE;
            S_1001: begin
                if (in) begin
                    state_nxt = S_1;
                end else begin
                    detect = 1'b1;
                    // Trailing "10" of a hit seeds the next match only in overlap mode.
                    state_nxt = (OVERLAP != 0) ? S_10 : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                detect    = 1'b0;
            end
        endcase
    end

    assign out = detect & ~rst_n;

endmodule

// File: tb/tb_mealy_seq_det_10010_sar.sv
// Scoreboard bench for the 1-0-0-1-0 detector, overlap and non-overlap instances side by side.
// Expected flags come from a bit-history model; a negedge monitor pops and compares.
module tb_mealy_seq_det_10010_sar;
    import mealy_seq_det_10010_sar_pkg::*;

    typedef struct packed {
        logic ov;
        logic no;
    } exp_t;

    logic clk;
    logic rst_n;
    logic bit_in;
    logic out_ov;
    logic out_no;

    int compared   = 0;
    int mismatched = 0;
    int pulse_ov   = 0;
    int pulse_no   = 0;

    exp_t sb_q[$];
    logic hist_ov[$];
    logic hist_no[$];
    exp_t mon_e;

    mealy_seq_det_10010_sar #(.OVERLAP(1)) dut_ov (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (bit_in),
        .out  (out_ov)
    );

    mealy_seq_det_10010_sar #(.OVERLAP(0)) dut_no (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (bit_in),
        .out  (out_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // True when the bits received so far end in 1,0,0,1,0.
    function automatic logic ends_in_pattern(input logic q[$]);
        logic [4:0] pat;
        int n;
        pat = 5'b10010;
        n   = q.size();
        if (n < 5) return 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (q[n-5+i] != pat[4-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input logic r, input logic b);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n  = r;
        bit_in = b;
        if (r) begin
            hist_ov.delete();
            hist_no.delete();
            e = '0;
        end else begin
            hist_ov.push_back(b);
            hist_no.push_back(b);
            e.ov = ends_in_pattern(hist_ov);
            e.no = ends_in_pattern(hist_no);
            if (e.no) hist_no.delete();
            while (hist_ov.size() > 8) void'(hist_ov.pop_front());
        end
        sb_q.push_back(e);
    endtask

    // Plays n bits of v, most significant first, with reset released.
    task automatic play(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, v[i]);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: scoreboard still holds %0d entries, required 0", sb_q.size());
        end
    endtask

    task automatic check_pulses(input string name, input int base_ov, input int base_no,
                                input int want_ov, input int want_no);
        compared++;
        if (pulse_ov - base_ov != want_ov) begin
            mismatched++;
            $display("FAIL %s overlap pulses: got %0d, required %0d", name, pulse_ov - base_ov, want_ov);
        end
        compared++;
        if (pulse_no - base_no != want_no) begin
            mismatched++;
            $display("FAIL %s non-overlap pulses: got %0d, required %0d", name, pulse_no - base_no, want_no);
        end
    endtask

    always @(negedge clk) begin
        if (out_ov) pulse_ov++;
        if (out_no) pulse_no++;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            compared++;
            if (out_ov !== mon_e.ov) begin
                mismatched++;
                $display("FAIL out_overlap @%0t: got %b, required %b", $time, out_ov, mon_e.ov);
            end
            compared++;
            if (out_no !== mon_e.no) begin
                mismatched++;
                $display("FAIL out_nonoverlap @%0t: got %b, required %b", $time, out_no, mon_e.no);
            end
        end
    end

    initial begin
        int b_ov;
        int b_no;
        logic r;
        logic b;
        rst_n  = 1'b1;
        bit_in = 1'b0;
        #2;
        compared++;
        if (dut_ov.state !== S_IDLE || dut_no.state !== S_IDLE) begin
            mismatched++;
            $display("FAIL reset_state: got %0d/%0d, required %0d", dut_ov.state, dut_no.state, S_IDLE);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        drain();

        // Single pattern after reset.
        b_ov = pulse_ov; b_no = pulse_no;
        step(1'b1, 1'b0);
        play(32'b10010, 5);
        drain();
        check_pulses("single", b_ov, b_no, 1, 1);

        // Overlapping pair.
        b_ov = pulse_ov; b_no = pulse_no;
        step(1'b1, 1'b0);
        play(32'b10010010, 8);
        drain();
        check_pulses("overlap_pair", b_ov, b_no, 2, 1);

        // Mixed stream with a non-matching tail.
        b_ov = pulse_ov; b_no = pulse_no;
        step(1'b1, 1'b0);
        play(32'b101010010010110, 15);
        drain();
        check_pulses("mixed_stream", b_ov, b_no, 2, 1);

        // Reset in the middle of a prefix discards it.
        b_ov = pulse_ov; b_no = pulse_no;
        step(1'b1, 1'b0);
        play(32'b1001, 4);
        step(1'b1, 1'b0);
        play(32'b0, 1);
        play(32'b10010, 5);
        drain();
        check_pulses("mid_reset", b_ov, b_no, 1, 1);

        // Long runs of constant input.
        b_ov = pulse_ov; b_no = pulse_no;
        step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        drain();
        check_pulses("const_runs", b_ov, b_no, 0, 0);

        // Pattern driven while reset is held.
        b_ov = pulse_ov; b_no = pulse_no;
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b1); step(1'b1, 1'b0);
        drain();
        check_pulses("held_reset", b_ov, b_no, 0, 0);
        compared++;
        if (dut_ov.state !== S_IDLE || dut_no.state !== S_IDLE) begin
            mismatched++;
            $display("FAIL held_reset_state: got %0d/%0d, required %0d", dut_ov.state, dut_no.state, S_IDLE);
        end

        // Random stream with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 63) == 0);
            b = 1'($urandom_range(0, 1));
            step(r, b);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
